// File: rtl/trap_pkg.sv
// -----------------------------------------------------------------------------
// trap_pkg
// Shared definitions for the supervisor trap controller:
//   - trap_state_t : FSM state encoding used by trap_controller
//   - CSR_*        : CSR addresses decoded by trap_csr_file
//   - PC_W         : program counter width (all PC arithmetic is mod 2^PC_W)
//   - STVEC_RESET  : value stvec takes while rst_n is low
//   - align_pc     : truncates a 64-bit write value to a word-aligned PC
// -----------------------------------------------------------------------------
package trap_pkg;

  localparam int PC_W = 15;

  localparam logic [11:0] CSR_STVEC  = 12'h105;
  localparam logic [11:0] CSR_SEPC   = 12'h141;
  localparam logic [11:0] CSR_SCAUSE = 12'h142;

  localparam logic [PC_W-1:0] STVEC_RESET = 15'h0040;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FLUSH    = 3'd1,
    ST_REDIRECT = 3'd2,
    ST_HANDLER  = 3'd3,
    ST_RETURN   = 3'd4
  } trap_state_t;

  // Keep the low PC_W bits and clear the two LSBs (instructions are
  // word aligned, so a PC-valued CSR never holds a misaligned address).
  function automatic logic [PC_W-1:0] align_pc(input logic [63:0] value);
    logic [PC_W-1:0] pc;
    pc = value[PC_W-1:0];
    pc[1:0] = 2'b00;
    return pc;
  endfunction

endpackage

// File: rtl/trap_csr_file.sv
// -----------------------------------------------------------------------------
// trap_csr_file
// Holds the supervisor trap CSRs (stvec, sepc, scause), the software read mux
// and the handler target address computation.
//
// Configuration macro: TRAP_VECTORED_EN
//   defined   : target = stvec + (scause[3:0] << 2) when scause[63] = 1
//   undefined : target = stvec always
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   capture               trap entry: load sepc_in/scause_in this edge
//   sepc_in, scause_in    faulting PC and cause code to capture
//   csr_we/addr/wdata     software CSR write
//   csr_rdata             combinational read of csr_addr (0 when unmapped)
//   sepc                  current sepc value (return address)
//   trap_target           handler entry address
// -----------------------------------------------------------------------------
module trap_csr_file
  import trap_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            capture,
  input  logic [PC_W-1:0] sepc_in,
  input  logic [63:0]     scause_in,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [63:0]     csr_wdata,
  output logic [63:0]     csr_rdata,
  output logic [PC_W-1:0] sepc,
  output logic [PC_W-1:0] trap_target
);

  logic [PC_W-1:0] stvec_reg;
  logic [PC_W-1:0] sepc_reg;
  logic [63:0]     scause_reg;

  logic wr_stvec;
  logic wr_sepc;
  logic wr_scause;

  assign wr_stvec  = csr_we && (csr_addr == CSR_STVEC);
  assign wr_sepc   = csr_we && (csr_addr == CSR_SEPC);
  assign wr_scause = csr_we && (csr_addr == CSR_SCAUSE);

  // stvec is never touched by hardware, so a software write always lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stvec_reg <= STVEC_RESET;
    end else if (wr_stvec) begin
      stvec_reg <= align_pc(csr_wdata);
    end
  end

  // Hardware capture at trap entry takes priority over a same-edge
  // software write so the faulting context is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sepc_reg   <= '0;
      scause_reg <= '0;
    end else if (capture) begin
      sepc_reg   <= sepc_in;
      scause_reg <= scause_in;
    end else begin
      if (wr_sepc) begin
        sepc_reg <= align_pc(csr_wdata);
      end
      if (wr_scause) begin
        scause_reg <= csr_wdata;
      end
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_STVEC:  csr_rdata = {{(64-PC_W){1'b0}}, stvec_reg};
      CSR_SEPC:   csr_rdata = {{(64-PC_W){1'b0}}, sepc_reg};
      CSR_SCAUSE: csr_rdata = scause_reg;
      default:    csr_rdata = '0;
    endcase
  end

`ifdef TRAP_VECTORED_EN
  // Interrupt causes (MSB set) vector to stvec + 4*code; the add wraps
  // naturally at PC_W bits.
  always_comb begin
    trap_target = stvec_reg;
    if (scause_reg[63]) begin
      trap_target = stvec_reg + {{(PC_W-6){1'b0}}, scause_reg[3:0], 2'b00};
    end
  end
`else
  assign trap_target = stvec_reg;
`endif

  assign sepc = sepc_reg;

endmodule

// File: rtl/trap_controller.sv
// -----------------------------------------------------------------------------
// trap_controller
// Supervisor trap sequencer: on an exception it captures the faulting context,
// squashes the pipeline for one cycle, redirects fetch to the handler and
// holds in_trap until sret, which flushes and redirects back to sepc.
//
// Configuration macro: TRAP_VECTORED_EN (vectored handler target, see
// trap_csr_file).
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   exception             exception flag (level, valid per cycle)
//   sepc_in, scause_in    faulting PC and cause code
//   sret                  return-from-trap instruction in EXE
//   csr_we/addr/wdata     software CSR write
//   csr_rdata             combinational CSR read, 0 for unmapped addresses
//   flush                 squash IF/ID, ID/EXE, EXE/MEM
//   pc_redirect           fetch PC override valid
//   redirect_pc           fetch PC override value
//   in_trap               handler is running
//   double_fault          sticky: exception taken while in the handler
// -----------------------------------------------------------------------------
module trap_controller
  import trap_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exception,
  input  logic [PC_W-1:0] sepc_in,
  input  logic [63:0]     scause_in,
  input  logic            sret,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [63:0]     csr_wdata,
  output logic [63:0]     csr_rdata,
  output logic            flush,
  output logic            pc_redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            in_trap,
  output logic            double_fault
);

  trap_state_t state_reg, state_next;
  logic        double_fault_reg, double_fault_next;
  logic        capture;
  logic [PC_W-1:0] sepc;
  logic [PC_W-1:0] trap_target;

  // Context is captured only on a fresh trap; a nested exception in the
  // handler keeps the original sepc/scause.
  assign capture = (state_reg == ST_IDLE) && exception;

  trap_csr_file u_csr (
    .clk         (clk),
    .rst_n       (rst_n),
    .capture     (capture),
    .sepc_in     (sepc_in),
    .scause_in   (scause_in),
    .csr_we      (csr_we),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .sepc        (sepc),
    .trap_target (trap_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      double_fault_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      double_fault_reg <= double_fault_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    double_fault_next = double_fault_reg;
    flush             = 1'b0;
    pc_redirect       = 1'b0;
    redirect_pc       = '0;
    in_trap           = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (exception) begin
          state_next = ST_FLUSH;
        end
      end
      // Exceptions raised here belong to instructions being squashed.
      ST_FLUSH: begin
        flush      = 1'b1;
        state_next = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        pc_redirect = 1'b1;
        redirect_pc = trap_target;
        state_next  = ST_HANDLER;
      end
      ST_HANDLER: begin
        in_trap = 1'b1;
        // A fault inside the handler outranks a simultaneous sret.
        if (exception) begin
          double_fault_next = 1'b1;
          state_next        = ST_FLUSH;
        end else if (sret) begin
          state_next = ST_RETURN;
        end
      end
      ST_RETURN: begin
        flush       = 1'b1;
        pc_redirect = 1'b1;
        redirect_pc = sepc;
        state_next  = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign double_fault = double_fault_reg;

endmodule

// File: tb/tb_trap_controller.sv
// -----------------------------------------------------------------------------
// tb_trap_controller
// Directed self-checking bench for trap_controller. Inputs are driven on the
// falling edge, outputs are checked on the following falling edge.
// -----------------------------------------------------------------------------
module tb_trap_controller;

  logic        clk;
  logic        rst_n;
  logic        exception;
  logic [14:0] sepc_in;
  logic [63:0] scause_in;
  logic        sret;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata;
  logic [63:0] csr_rdata;
  logic        flush;
  logic        pc_redirect;
  logic [14:0] redirect_pc;
  logic        in_trap;
  logic        double_fault;

  int checks;
  int errors;

  logic [14:0] exp_vec_target;

  trap_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .exception    (exception),
    .sepc_in      (sepc_in),
    .scause_in    (scause_in),
    .sret         (sret),
    .csr_we       (csr_we),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .csr_rdata    (csr_rdata),
    .flush        (flush),
    .pc_redirect  (pc_redirect),
    .redirect_pc  (redirect_pc),
    .in_trap      (in_trap),
    .double_fault (double_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // One clock: rising edge, then settle to the falling edge for checking.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input logic f, input logic r,
                            input logic [14:0] pc, input logic t, input logic d);
    check({tag, ".flush"},        flush,        f);
    check({tag, ".pc_redirect"},  pc_redirect,  r);
    check({tag, ".redirect_pc"},  redirect_pc,  pc);
    check({tag, ".in_trap"},      in_trap,      t);
    check({tag, ".double_fault"}, double_fault, d);
  endtask

  task automatic read_csr(input string tag, input logic [11:0] addr, input logic [63:0] exp);
    csr_addr = addr;
    #1;
    check(tag, csr_rdata, exp);
  endtask

  task automatic write_csr(input logic [11:0] addr, input logic [63:0] data);
    csr_we    = 1'b1;
    csr_addr  = addr;
    csr_wdata = data;
    step();
    csr_we    = 1'b0;
    csr_wdata = '0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    exception = 1'b0;
    sepc_in   = '0;
    scause_in = '0;
    sret      = 1'b0;
    csr_we    = 1'b0;
    csr_addr  = '0;
    csr_wdata = '0;

`ifdef TRAP_VECTORED_EN
    exp_vec_target = 15'h0114;
`else
    exp_vec_target = 15'h0100;
`endif

    // Reset, then idle five cycles.
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();
    check_outs("idle", 1'b0, 1'b0, 15'h0, 1'b0, 1'b0);
    read_csr("idle.stvec", 12'h105, 64'h40);
    read_csr("idle.sepc", 12'h141, 64'h0);
    read_csr("idle.scause", 12'h142, 64'h0);
    read_csr("idle.unmapped", 12'h123, 64'h0);

    // Trap entry: flush at +1, redirect to stvec at +2, handler at +3.
    exception = 1'b1;
    sepc_in   = 15'h1000;
    scause_in = 64'd2;
    step();
    exception = 1'b0;
    sepc_in   = '0;
    scause_in = '0;
    check_outs("t1.flush", 1'b1, 1'b0, 15'h0, 1'b0, 1'b0);
    step();
    check_outs("t1.redir", 1'b0, 1'b1, 15'h0040, 1'b0, 1'b0);
    step();
    check_outs("t1.handler", 1'b0, 1'b0, 15'h0, 1'b1, 1'b0);
    read_csr("t1.sepc", 12'h141, 64'h1000);
    read_csr("t1.scause", 12'h142, 64'd2);
    step();
    check("t1.handler_hold", in_trap, 1'b1);

    // sret: one cycle flush + redirect to sepc, then idle.
    sret = 1'b1;
    step();
    sret = 1'b0;
    check_outs("t1.return", 1'b1, 1'b1, 15'h1000, 1'b0, 1'b0);
    step();
    check_outs("t1.idle", 1'b0, 1'b0, 15'h0, 1'b0, 1'b0);

    // sret while idle has no effect.
    sret = 1'b1;
    step();
    sret = 1'b0;
    check_outs("idle_sret", 1'b0, 1'b0, 15'h0, 1'b0, 1'b0);

    // Second trap, then exception+sret together inside the handler.
    exception = 1'b1;
    sepc_in   = 15'h1000;
    scause_in = 64'd2;
    step();
    exception = 1'b0;
    step();
    step();
    check("t2.in_trap", in_trap, 1'b1);
    exception = 1'b1;
    sret      = 1'b1;
    sepc_in   = 15'h2220;
    scause_in = 64'd7;
    step();
    sret = 1'b0;
    // exception stays high during FLUSH: must be ignored.
    check_outs("df.flush", 1'b1, 1'b0, 15'h0, 1'b0, 1'b1);
    read_csr("df.sepc", 12'h141, 64'h1000);
    read_csr("df.scause", 12'h142, 64'd2);
    step();
    exception = 1'b0;
    check_outs("df.redir", 1'b0, 1'b1, 15'h0040, 1'b0, 1'b1);
    step();
    check_outs("df.handler", 1'b0, 1'b0, 15'h0, 1'b1, 1'b1);
    sret = 1'b1;
    step();
    sret = 1'b0;
    check_outs("df.return", 1'b1, 1'b1, 15'h1000, 1'b0, 1'b1);
    step();
    check_outs("df.idle", 1'b0, 1'b0, 15'h0, 1'b0, 1'b1);

    // Software CSR writes: truncation and low-bit clearing.
    write_csr(12'h105, 64'hFFFF_0000_0000_0103);
    read_csr("wr.stvec", 12'h105, 64'h0100);
    write_csr(12'h141, 64'h1234_5677);
    read_csr("wr.sepc", 12'h141, 64'h5674);
    write_csr(12'h142, 64'h8000_0000_0000_000B);
    read_csr("wr.scause", 12'h142, 64'h8000_0000_0000_000B);

    // Capture beats a same-edge sepc write; vectored target check.
    exception = 1'b1;
    sepc_in   = 15'h0AB0;
    scause_in = 64'h8000_0000_0000_0005;
    csr_we    = 1'b1;
    csr_addr  = 12'h141;
    csr_wdata = 64'h0FF0;
    step();
    exception = 1'b0;
    csr_we    = 1'b0;
    read_csr("cap.sepc", 12'h141, 64'h0AB0);
    read_csr("cap.scause", 12'h142, 64'h8000_0000_0000_0005);
    check("cap.flush", flush, 1'b1);
    step();
    check("vec.pc_redirect", pc_redirect, 1'b1);
    check("vec.redirect_pc", redirect_pc, exp_vec_target);

    // Asynchronous reset during REDIRECT.
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("arst", 1'b0, 1'b0, 15'h0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    check_outs("arst.after1", 1'b0, 1'b0, 15'h0, 1'b0, 1'b0);
    step();
    check_outs("arst.after2", 1'b0, 1'b0, 15'h0, 1'b0, 1'b0);
    read_csr("arst.stvec", 12'h105, 64'h40);
    read_csr("arst.sepc", 12'h141, 64'h0);
    read_csr("arst.scause", 12'h142, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports: exception  in  1  exception flag from exception_handler, level, valid per cycle.
REQ-004 SHALL have ports: sepc_in  in  15  faulting PC from exception_handler.
REQ-005 SHALL have ports: scause_in  in  64  cause code from exception_handler.
REQ-006 SHALL have ports: sret  in  1  return-from-trap instruction in EXE.
REQ-007 SHALL have ports: csr_we  in  1, csr_addr  in  12, csr_wdata  in  64  software CSR write.
REQ-008 SHALL have ports: csr_rdata  out  64  combinational read of csr_addr; 0 for unmapped.
REQ-009 SHALL have ports: flush  out  1  squash IF/ID, ID/EXE, EXE/MEM.
REQ-010 SHALL have ports: pc_redirect  out  1, redirect_pc  out  15  PC override to fetch.
REQ-011 SHALL have ports: in_trap  out  1  handler running; double_fault  out  1  sticky.
REQ-012 SHALL map CSRs: stvec 0x105 (15 b, zero-extended on read), sepc 0x141 (15 b), scause 0x142 (64 b).

Function
REQ-013 SHALL implement FSM states IDLE, FLUSH, REDIRECT, HANDLER, RETURN.
REQ-014 IDLE, exception=1 at edge: capture sepc_in/scause_in, go FLUSH.
REQ-015 FLUSH: flush=1 exactly one cycle, go REDIRECT.
REQ-016 REDIRECT: pc_redirect=1, redirect_pc=target (REQ-026), one cycle, go HANDLER.
REQ-017 HANDLER: in_trap=1; sret=1 -> RETURN.
REQ-018 RETURN: flush=1, pc_redirect=1, redirect_pc=sepc register, one cycle, go IDLE.
REQ-019 Exception-to-redirect latency SHALL be 2 cycles after capture edge; total 3 edges from exception to HANDLER.
REQ-020 Exceptions in FLUSH/REDIRECT/RETURN SHALL be ignored (pipeline being squashed).
REQ-021 Exception in HANDLER SHALL set double_fault, keep sepc/scause unchanged, go FLUSH.
REQ-022 exception and sret same cycle in HANDLER: exception wins (REQ-021).
REQ-023 sret in IDLE SHALL be ignored.
REQ-024 csr_we writes target CSR at edge; same-edge capture (REQ-014) SHALL win over csr_we for sepc/scause; stvec write always taken.
REQ-025 csr_wdata to 15-b CSRs SHALL truncate to bits [14:0], bits [1:0] forced 0 for stvec/sepc.
REQ-026 Target = stvec (direct); all PC arithmetic modulo 2^15.
REQ-027 double_fault SHALL clear only on reset.

Reset
REQ-028 rst_n=0 SHALL immediately force: state IDLE, flush=0, pc_redirect=0, redirect_pc=0, in_trap=0, double_fault=0, sepc=0, scause=0, stvec=15'h0040.
REQ-029 Reset mid-trap SHALL abandon trap with no redirect after release.

Configuration
REQ-030 Macro TRAP_VECTORED_EN defined: target = stvec + (scause[3:0] << 2), mod 2^15, when scause[63]=1; else stvec.
REQ-031 Macro undefined: target = stvec always; scause[63] has no effect.

Structure
REQ-032 Shared package trap_pkg SHALL hold FSM state enum, CSR address constants, STVEC_RESET value, PC width (15).
REQ-033 One sub-module trap_csr_file (sepc/scause/stvec registers plus read mux) SHALL be used; FSM in top.

Verification
REQ-034 Reset, idle 5 cycles -> all outputs 0, csr_rdata@0x105 = 0x40.
REQ-035 exception=1, sepc_in=0x1000, scause_in=2 -> flush cycle+1, pc_redirect cycle+2 with 0x0040, sepc reads 0x1000, scause 2.
REQ-036 In HANDLER assert sret -> one cycle flush+pc_redirect to 0x1000, then IDLE, in_trap=0.
REQ-037 In HANDLER, exception and sret together -> double_fault=1, sepc stays 0x1000, redirect to stvec again.
REQ-038 TRAP_VECTORED_EN, stvec=0x0100, scause=64'h8000_0000_0000_0005 -> redirect_pc=0x0114; undefined -> 0x0100.
REQ-039 rst_n low during REDIRECT -> outputs 0 asynchronously, no redirect after release.
